proc_sequencer: RTL

- Instruction sequencer for one distributed-processor core: fetches instruction words, classifies the opcode and steps the core through its execute and wait phases.
- Owns the instruction pointer and all timing and handshake waits: qclk-timed pulses, sync barrier and fproc (function-processor) requests.
- Drives the single-cycle enable strobes consumed by the combinational control decoder and the datapath.

---
 rtl/proc_sequencer.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/proc_sequencer.sv
// Instruction sequencer for one core: fetch, opcode-class dispatch, qclk/sync/fproc waits.
// Optional watchdog on sync/fproc waits is compiled in with PROC_SEQ_TIMEOUT_EN.
module proc_sequencer #(
    parameter int ADDR_W         = 8,
    parameter int QCLK_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_rd_en,
    input  logic              instr_valid,
    input  logic [7:0]        opcode,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic [QCLK_W-1:0] cmd_time,
    input  logic              cond_true,
    input  logic [QCLK_W-1:0] qclk,
    output logic              pulse_strobe,
    output logic              reg_write_strobe,
    output logic              qclk_load,
    output logic              sync_out_valid,
    input  logic              sync_in_ready,
    output logic              fproc_out_valid,
    input  logic              fproc_in_valid,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FETCH      = 3'd1;
    localparam logic [2:0] S_WAIT_MEM   = 3'd2;
    localparam logic [2:0] S_EXEC       = 3'd3;
    localparam logic [2:0] S_WAIT_QCLK  = 3'd4;
    localparam logic [2:0] S_WAIT_SYNC  = 3'd5;
    localparam logic [2:0] S_WAIT_FPROC = 3'd6;
    localparam logic [2:0] S_HALT       = 3'd7;

    localparam logic [4:0] C_DONE        = 5'd0;
    localparam logic [4:0] C_PULSE_I     = 5'd1;
    localparam logic [4:0] C_REG_WRITE_I = 5'd2;
    localparam logic [4:0] C_REG_I_ALU   = 5'd3;
    localparam logic [4:0] C_REG_ALU     = 5'd4;
    localparam logic [4:0] C_JUMP_I      = 5'd5;
    localparam logic [4:0] C_JUMP_COND   = 5'd6;
    localparam logic [4:0] C_QCLK_LOAD   = 5'd7;
    localparam logic [4:0] C_SYNC        = 5'd8;
    localparam logic [4:0] C_FPROC       = 5'd9;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] ip;
    logic [ADDR_W-1:0] ip_nxt;
    logic [ADDR_W-1:0] ip_inc;
    logic [7:0]        opcode_q;
    logic [ADDR_W-1:0] jump_addr_q;
    logic [QCLK_W-1:0] cmd_time_q;
    logic [4:0]        exec_class;
    logic [4:0]        in_class;
    logic              start_ok;
    logic              set_done;
    logic              set_err;
    logic              qclk_due;
    logic              wait_expired;
    logic              in_is_reg;
    logic              unused_opcode_bits;

    assign exec_class         = opcode_q[7:3];
    assign in_class           = opcode[7:3];
    assign ip_inc             = ip + ADDR_W'(1);
    assign instr_addr         = ip;
    assign start_ok           = start && (state == S_IDLE || state == S_HALT);
    assign unused_opcode_bits = ^opcode_q[2:0];
    assign in_is_reg          = (in_class == C_REG_WRITE_I) || (in_class == C_REG_I_ALU) ||
                                (in_class == C_REG_ALU);

    // qclk is the core's own registered counter, so the compare fires in the matching cycle.
    assign qclk_due     = (state == S_WAIT_QCLK) && (qclk >= cmd_time_q);
    assign pulse_strobe = qclk_due;

`ifdef PROC_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            waiting;

    assign waiting      = (state == S_WAIT_SYNC) || (state == S_WAIT_FPROC);
    assign wait_expired = waiting && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (!waiting) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign wait_expired = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        ip_nxt    = ip;
        set_done  = 1'b0;
        set_err   = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    ip_nxt    = '0;
                end
            end
            S_FETCH: state_nxt = S_WAIT_MEM;
            S_WAIT_MEM: begin
                if (instr_valid) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                case (exec_class)
                    C_DONE: begin
                        state_nxt = S_HALT;
                        set_done  = 1'b1;
                    end
                    C_PULSE_I: state_nxt = S_WAIT_QCLK;
                    C_REG_WRITE_I, C_REG_I_ALU, C_REG_ALU, C_QCLK_LOAD: begin
                        state_nxt = S_FETCH;
                        ip_nxt    = ip_inc;
                    end
                    C_JUMP_I: begin
                        state_nxt = S_FETCH;
                        ip_nxt    = jump_addr_q;
                    end
                    C_JUMP_COND: begin
                        state_nxt = S_FETCH;
                        ip_nxt    = cond_true ? jump_addr_q : ip_inc;
                    end
                    C_SYNC:  state_nxt = S_WAIT_SYNC;
                    C_FPROC: state_nxt = S_WAIT_FPROC;
                    default: begin
                        state_nxt = S_HALT;
                        set_err   = 1'b1;
                    end
                endcase
            end
            S_WAIT_QCLK: begin
                if (qclk_due) begin
                    state_nxt = S_FETCH;
                    ip_nxt    = ip_inc;
                end
            end
            S_WAIT_SYNC: begin
                // A response in the expiry cycle still completes normally.
                if (sync_in_ready) begin
                    state_nxt = S_FETCH;
                    ip_nxt    = ip_inc;
                end else if (wait_expired) begin
                    state_nxt = S_HALT;
                    set_err   = 1'b1;
                end
            end
            S_WAIT_FPROC: begin
                if (fproc_in_valid) begin
                    state_nxt = S_FETCH;
                    ip_nxt    = ip_inc;
                end else if (wait_expired) begin
                    state_nxt = S_HALT;
                    set_err   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each is high exactly in its own state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            ip               <= '0;
            opcode_q         <= '0;
            jump_addr_q      <= '0;
            cmd_time_q       <= '0;
            instr_rd_en      <= 1'b0;
            reg_write_strobe <= 1'b0;
            qclk_load        <= 1'b0;
            sync_out_valid   <= 1'b0;
            fproc_out_valid  <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
        end else begin
            state <= state_nxt;
            ip    <= ip_nxt;
            if (state == S_WAIT_MEM && instr_valid) begin
                opcode_q    <= opcode;
                jump_addr_q <= jump_addr;
                cmd_time_q  <= cmd_time;
            end
            instr_rd_en      <= (state_nxt == S_FETCH);
            reg_write_strobe <= (state_nxt == S_EXEC) && in_is_reg;
            qclk_load        <= (state_nxt == S_EXEC) && (in_class == C_QCLK_LOAD);
            sync_out_valid   <= (state_nxt == S_WAIT_SYNC);
            fproc_out_valid  <= (state_nxt == S_WAIT_FPROC);
            if (start_ok) begin
                busy  <= 1'b1;
                done  <= 1'b0;
                error <= 1'b0;
            end else if (set_done) begin
                done <= 1'b1;
                busy <= 1'b0;
            end else if (set_err) begin
                error <= 1'b1;
                busy  <= 1'b0;
            end
        end
    end

endmodule
